// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - load/compute sequencer for the two-layer convolution engine
module conv_seq_ctrl #(
   parameter int DATA_N   = 64,
   parameter int WGT_N    = 54,
   parameter int PIPE_LAT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic       ram_en,
   input  logic [7:0] din,
   output logic [7:0] wr_data,
   output logic       data_we,
   output logic [5:0] data_waddr,
   output logic       wgt_we,
   output logic [5:0] wgt_waddr,
   output logic       busy,
   output logic       pe_en,
   output logic       layer,
   output logic [2:0] win_row,
   output logic [2:0] win_col,
   output logic       wb_en,
   output logic [5:0] wb_addr,
   output logic       pool_clr,
   output logic       pool_en,
   output logic       out_load,
   output logic       out_data_flag
);

   typedef enum logic [2:0] {
      S_LOAD, S_RUN1, S_DRAIN1, S_RUN2, S_DRAIN2, S_OUT, S_DONE
   } state_t;

   localparam logic [6:0] DATA_LIM   = 7'(DATA_N);
   localparam logic [5:0] WGT_LIM    = 6'(WGT_N);
   localparam logic [2:0] DRAIN_LAST = 3'(PIPE_LAT - 1);

   state_t     state_q, state_d;
   logic [6:0] data_cnt_q, data_cnt_d;
   logic [5:0] wgt_cnt_q, wgt_cnt_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic       data_we_q, data_we_d;
   logic [5:0] data_waddr_q, data_waddr_d;
   logic       wgt_we_q, wgt_we_d;
   logic [5:0] wgt_waddr_q, wgt_waddr_d;
   logic [2:0] win_row_q, win_row_d;
   logic [2:0] win_col_q, win_col_d;
   logic       layer_q, layer_d;
   logic [2:0] drain_cnt_q, drain_cnt_d;

   // Delay line carrying each evaluated window to its write-back slot
   logic [PIPE_LAT-1:0]      pe_pipe_q, pe_pipe_d;
   logic [PIPE_LAT-1:0]      lyr_pipe_q, lyr_pipe_d;
   logic [PIPE_LAT-1:0][5:0] addr_pipe_q, addr_pipe_d;
   logic [5:0]               cur_addr;

   // Status and compute strobes decode directly from the state register
   assign pe_en         = (state_q == S_RUN1) || (state_q == S_RUN2);
   assign busy          = (state_q != S_LOAD) && (state_q != S_DONE);
   assign out_load      = (state_q == S_OUT);
   assign out_data_flag = (state_q == S_DONE);
   assign wr_data       = wr_data_q;
   assign data_we       = data_we_q;
   assign data_waddr    = data_waddr_q;
   assign wgt_we        = wgt_we_q;
   assign wgt_waddr     = wgt_waddr_q;
   assign win_row       = win_row_q;
   assign win_col       = win_col_q;
   assign layer         = layer_q;
   assign wb_en         = pe_pipe_q[PIPE_LAT-1];
   assign wb_addr       = addr_pipe_q[PIPE_LAT-1];
   assign pool_en       = pe_pipe_q[PIPE_LAT-1] & lyr_pipe_q[PIPE_LAT-1];
   assign pool_clr      = pool_en && (addr_pipe_q[PIPE_LAT-1] == 6'd0);

   // Linear result index of the window being evaluated now
   always_comb begin
      cur_addr = 6'd0;
      if (layer_q) begin
         cur_addr = {2'b00, win_row_q[1:0], win_col_q[1:0]};
      end else begin
         cur_addr = ({3'b000, win_row_q} * 6'd6) + {3'b000, win_col_q};
      end
   end

   // Shift the window valid/layer/index down the write-back delay line
   always_comb begin
      pe_pipe_d      = '0;
      lyr_pipe_d     = '0;
      addr_pipe_d    = '0;
      pe_pipe_d[0]   = pe_en;
      lyr_pipe_d[0]  = layer_q;
      addr_pipe_d[0] = cur_addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
         pe_pipe_d[i]   = pe_pipe_q[i-1];
         lyr_pipe_d[i]  = lyr_pipe_q[i-1];
         addr_pipe_d[i] = addr_pipe_q[i-1];
      end
   end

   // Next-state, load strobes and window scan
   always_comb begin
      state_d      = state_q;
      data_cnt_d   = data_cnt_q;
      wgt_cnt_d    = wgt_cnt_q;
      wr_data_d    = wr_data_q;
      data_we_d    = 1'b0;
      data_waddr_d = data_waddr_q;
      wgt_we_d     = 1'b0;
      wgt_waddr_d  = wgt_waddr_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      layer_d      = layer_q;
      drain_cnt_d  = drain_cnt_q;
      case (state_q)
         S_LOAD: begin
            if (ram_en) begin
               if (!mode) begin
                  if (data_cnt_q < DATA_LIM) begin
                     data_we_d    = 1'b1;
                     data_waddr_d = data_cnt_q[5:0];
                     wr_data_d    = din;
                     data_cnt_d   = data_cnt_q + 7'd1;
                  end
               end else begin
                  if (wgt_cnt_q < WGT_LIM) begin
                     wgt_we_d    = 1'b1;
                     wgt_waddr_d = wgt_cnt_q;
                     wr_data_d   = din;
                     wgt_cnt_d   = wgt_cnt_q + 6'd1;
                  end
               end
            end else if ((data_cnt_q == DATA_LIM) && (wgt_cnt_q == WGT_LIM)) begin
               state_d   = S_RUN1;
               win_row_d = 3'd0;
               win_col_d = 3'd0;
               layer_d   = 1'b0;
            end
         end
         S_RUN1: begin
            if ((win_row_q == 3'd5) && (win_col_q == 3'd5)) begin
               state_d     = S_DRAIN1;
               drain_cnt_d = 3'd0;
            end else if (win_col_q == 3'd5) begin
               win_col_d = 3'd0;
               win_row_d = win_row_q + 3'd1;
            end else begin
               win_col_d = win_col_q + 3'd1;
            end
         end
         S_DRAIN1: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d   = S_RUN2;
               win_row_d = 3'd0;
               win_col_d = 3'd0;
               layer_d   = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 3'd1;
            end
         end
         S_RUN2: begin
            if ((win_row_q == 3'd3) && (win_col_q == 3'd3)) begin
               state_d     = S_DRAIN2;
               drain_cnt_d = 3'd0;
            end else if (win_col_q == 3'd3) begin
               win_col_d = 3'd0;
               win_row_d = win_row_q + 3'd1;
            end else begin
               win_col_d = win_col_q + 3'd1;
            end
         end
         S_DRAIN2: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = S_OUT;
            end else begin
               drain_cnt_d = drain_cnt_q + 3'd1;
            end
         end
         S_OUT: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            // The byte that releases DONE is also the first byte of the next load
            if (ram_en) begin
               state_d    = S_LOAD;
               data_cnt_d = 7'd0;
               wgt_cnt_d  = 6'd0;
               wr_data_d  = din;
               if (!mode) begin
                  data_we_d    = 1'b1;
                  data_waddr_d = 6'd0;
                  data_cnt_d   = 7'd1;
               end else begin
                  wgt_we_d    = 1'b1;
                  wgt_waddr_d = 6'd0;
                  wgt_cnt_d   = 6'd1;
               end
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   // State, counters, registered outputs and delay line
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_LOAD;
         data_cnt_q   <= '0;
         wgt_cnt_q    <= '0;
         wr_data_q    <= '0;
         data_we_q    <= 1'b0;
         data_waddr_q <= '0;
         wgt_we_q     <= 1'b0;
         wgt_waddr_q  <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         layer_q      <= 1'b0;
         drain_cnt_q  <= '0;
         pe_pipe_q    <= '0;
         lyr_pipe_q   <= '0;
         addr_pipe_q  <= '0;
      end else begin
         state_q      <= state_d;
         data_cnt_q   <= data_cnt_d;
         wgt_cnt_q    <= wgt_cnt_d;
         wr_data_q    <= wr_data_d;
         data_we_q    <= data_we_d;
         data_waddr_q <= data_waddr_d;
         wgt_we_q     <= wgt_we_d;
         wgt_waddr_q  <= wgt_waddr_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         layer_q      <= layer_d;
         drain_cnt_q  <= drain_cnt_d;
         pe_pipe_q    <= pe_pipe_d;
         lyr_pipe_q   <= lyr_pipe_d;
         addr_pipe_q  <= addr_pipe_d;
      end
   end

endmodule

// File: doc/conv_seq_ctrl.md
# conv_seq_ctrl

Load-and-compute sequencer for the two-layer convolution engine. It takes the byte stream on `din`/`mode`/`ram_en` and generates write strobes and addresses for the input-feature RAM (64 B) and the weight RAM (54 B). Once both are full it sequences the compute:

- layer 1: 3 parallel 3x3x1 filters over the 8x8 input, giving 6x6x3;
- layer 2: one 3x3x3 filter over the 6x6x3 maps, giving 4x4;
- a running max-pool over the 16 layer-2 results, giving one output byte.

It sits between the top-level pins and the RAM/PE/pool datapath, and drives `out_data_flag`.

## Interface
- `DATA_N`, 64, input-feature bytes accepted per load
- `WGT_N`, 54, weight bytes accepted per load (27 for layer 1, then 27 for layer 2)
- `PIPE_LAT`, 2, cycles from `pe_en` to the matching `wb_en`; legal range 1..4
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = `din` is input data, 1 = `din` is weight
- `ram_en`  in  1  `din` byte valid this cycle
- `din`  in  8  load byte
- `wr_data`  out  8  registered `din`
- `data_we`  out  1  input-feature RAM write strobe
- `data_waddr`  out  6  input-feature RAM write address
- `wgt_we`  out  1  weight RAM write strobe
- `wgt_waddr`  out  6  weight RAM write address
- `busy`  out  1  high in RUN1..OUT
- `pe_en`  out  1  PE array evaluates the current window
- `layer`  out  1  0 = layer 1, 1 = layer 2
- `win_row`  out  3  window top-left row
- `win_col`  out  3  window top-left column
- `wb_en`  out  1  write back PE result
- `wb_addr`  out  6  result index
- `pool_clr`  out  1  pool register loads instead of max-compare
- `pool_en`  out  1  pool register update
- `out_load`  out  1  one-cycle pulse: copy pool register to `dout`
- `out_data_flag`  out  1  result valid

## Operation
- States: LOAD, RUN1, DRAIN1, RUN2, DRAIN2, OUT, DONE. Reset enters LOAD.
- Reset state: counters 0; every output 0.
- **LOAD, byte handling.** On each `ram_en`=1 cycle, `mode` selects the data counter (0..`DATA_N`) or the weight counter (0..`WGT_N`).
  - If the selected counter is below its limit: the next cycle presents `wr_data`=`din`, the matching `*_we`=1 and `*_waddr`=counter value; the counter then increments.
  - If the counter is at its limit: the byte is dropped and no strobe is issued.
  - `mode` may toggle freely; each counter keeps its own position.
- **LOAD exit.** When `ram_en`=0 and both counters are at their limits, go to RUN1. Otherwise stay in LOAD.
- **RUN1.** `layer`=0, `pe_en`=1 every cycle. `(win_row, win_col)` scans 0..5 x 0..5, row-major. After (5,5), go to DRAIN1.
- **DRAIN1.** `pe_en`=0 for exactly `PIPE_LAT` cycles, then go to RUN2.
- **RUN2.** `layer`=1, `pe_en`=1 every cycle. Scan 0..3 x 0..3, row-major, then go to DRAIN2 (`PIPE_LAT` cycles).
- **Write-back.** `wb_en` is `pe_en` delayed by exactly `PIPE_LAT` cycles. `wb_addr` is the delayed row*6+col (layer 1, 0..35; all three maps written together) or row*4+col (layer 2, 0..15).
- **Pooling.**
  - `pool_en` = delayed `pe_en` AND delayed `layer`.
  - `pool_clr` = `pool_en` on the index-0 layer-2 write-back only.
- **OUT.** `out_load`=1 for one cycle, then go to DONE.
- **DONE.** `out_data_flag`=1 and held. The first `ram_en`=1 in DONE does all of the following:
  - clears the flag next cycle;
  - zeroes both counters;
  - writes that byte at address 0 of the RAM selected by `mode`;
  - returns to LOAD.
- `ram_en` during RUN1..OUT is ignored: no strobes, no counter change.
- `win_row`/`win_col`/`layer` hold their last value while `pe_en`=0.

## Timing
- Load strobe latency: 1 cycle after the sampled `ram_en`.
- Let C0 be the edge at which LOAD sees `ram_en`=0 with full counters. Cycles numbered after C0:
  - `pe_en` L1: 1..36
  - `wb_en` L1: 3..38
  - DRAIN1: 37..38
  - `pe_en` L2: 39..54
  - `wb_en`/`pool_en`: 41..56
  - `pool_clr`: 41
  - DRAIN2: 55..56
  - `out_load`: 57
  - `out_data_flag` rises: 58
- For general `PIPE_LAT`, `out_load` occurs at cycle 53+2·`PIPE_LAT`.
- `busy` is high from cycle 1 through the `out_load` cycle.
- `rst` mid-operation: the next cycle has all outputs 0 and the state is LOAD. No partial `wb_en` or `pool_en` leaks out of the delay pipeline.

## Test plan
- **Nominal load and compute.** Stimulus: 64 data bytes at `mode`=0, then 54 weight bytes at `mode`=1, then `ram_en`=0. Required: `data_waddr` 0..63 and `wgt_waddr` 0..53, each strobe 1 cycle after its byte; the `pe_en`/`wb_en`/`pool_*` cycles listed in Timing relative to C0; `out_data_flag`=1 from C0+58.
- **Overflow.** Stimulus: 70 data bytes, then 54 weights. Required: exactly 64 `data_we` pulses; the last 6 bytes produce no strobe; compute still starts.
- **Incomplete load.** Stimulus: 64 data bytes, 50 weights, `ram_en`=0 for 10 cycles. Required: `pe_en` stays 0. Then 4 more weights: `wgt_waddr` 50..53, after which RUN1 starts.
- **Traffic while busy.** Stimulus: `ram_en`=1 with random `din` during RUN1 and RUN2. Required: no `*_we` pulses; schedule unchanged (`out_load` still at C0+57).
- **Reset mid-run.** Stimulus: `rst`=1 for 1 cycle at C0+45. Required: next cycle `pe_en`=`wb_en`=`pool_en`=`busy`=0; a full reload then completes normally.
- **Back-to-back loads.** Stimulus: `ram_en`=1, `mode`=0 in DONE. Required: `out_data_flag`=0 next cycle, with `data_we`=1 and `data_waddr`=0.
